pipe_ctrl: RTL

Pipelined control unit for the five-stage RV32I PCPU (IF/ID/EX/MEM/WB). It decodes the instruction held in IF/ID and carries the control word through its own ID/EX, EX/MEM and MEM/WB registers. It detects load-use and RAW hazards and issues stall, flush and forwarding selects. It sits beside the datapath pipeline registers and drives every control input of ALU, EXT, NPC, DM and RF.

---
 rtl/pipe_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module   : pipe_ctrl
// Desc     : Pipelined control unit for the five-stage RV32I core. Decodes
//            the IF/ID instruction, carries the control word through
//            ID/EX, EX/MEM and MEM/WB, resolves branches in EX and
//            generates stall, flush and operand-forwarding selects.
// Option   : FORWARD_EN - define to enable EX/MEM and MEM/WB forwarding;
//            undefined, every RAW dependence stalls until the writer retires.
// Revision : 1.0 - initial release
//============================================================================
module pipe_ctrl #(
    parameter int ALUOP_W  = 5,
    parameter int DMTYPE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         id_instr,
    input  logic                id_valid,
    input  logic                ex_zero,
    output logic                stall_o,
    output logic                flush_o,
    output logic [5:0]          id_EXTOp,
    output logic [ALUOP_W-1:0]  ex_ALUOp,
    output logic                ex_ALUSrc,
    output logic [2:0]          ex_NPCOp,
    output logic [1:0]          ex_fwdA,
    output logic [1:0]          ex_fwdB,
    output logic                mem_MemWrite,
    output logic [DMTYPE_W-1:0] mem_DMType,
    output logic                wb_RegWrite,
    output logic [1:0]          wb_WDSel,
    output logic [4:0]          wb_rd
);

    // Opcodes
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    // ALU operation codes shared with the ALU
    localparam logic [ALUOP_W-1:0] c_ALU_LUI   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_AUIPC = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_ADD   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_ALU_SLT   = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] c_ALU_SLTU  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] c_ALU_XOR   = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] c_ALU_OR    = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] c_ALU_AND   = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] c_ALU_SLL   = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] c_ALU_SRL   = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] c_ALU_SRA   = ALUOP_W'(17);

    // Data-memory access types
    localparam logic [DMTYPE_W-1:0] c_DM_W  = DMTYPE_W'(0);
    localparam logic [DMTYPE_W-1:0] c_DM_H  = DMTYPE_W'(1);
    localparam logic [DMTYPE_W-1:0] c_DM_HU = DMTYPE_W'(2);
    localparam logic [DMTYPE_W-1:0] c_DM_B  = DMTYPE_W'(3);
    localparam logic [DMTYPE_W-1:0] c_DM_BU = DMTYPE_W'(4);

    // Control word carried from ID into EX; all-zero is the bubble
    typedef struct packed {
        logic [ALUOP_W-1:0]  alu_op;
        logic                alu_src;
        logic                branch;
        logic [2:0]          funct3;
        logic                jal;
        logic                jalr;
        logic                mem_write;
        logic [DMTYPE_W-1:0] dm_type;
        logic                load;
        logic                reg_write;
        logic [1:0]          wd_sel;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
    } idex_t;

    typedef struct packed {
        logic                mem_write;
        logic [DMTYPE_W-1:0] dm_type;
        logic                reg_write;
        logic [1:0]          wd_sel;
        logic [4:0]          rd;
    } exmem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wd_sel;
        logic [4:0] rd;
    } memwb_t;

    wire logic [6:0] w_opcode = id_instr[6:0];
    wire logic [2:0] w_funct3 = id_instr[14:12];
    wire logic [6:0] w_funct7 = id_instr[31:25];

    idex_t  w_dec;
    idex_t  r_idex;
    exmem_t r_exmem;
    memwb_t r_memwb;
    logic [5:0] w_ext;
    logic       w_known;
    logic       w_use1;
    logic       w_use2;
    logic       w_has_rd;
    logic       w_taken;
    logic       w_hazard;

    // A write-enabled stage with rd!=0 that matches either source register
    function automatic logic f_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] a, input logic [4:0] b);
        return we && (rd != 5'd0) && ((rd == a) || (rd == b));
    endfunction

    // Instruction decode; unknown encodings and invalid slots become a bubble
    always_comb begin
        w_dec    = '0;
        w_ext    = 6'b000000;
        w_known  = 1'b1;
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_has_rd = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_use1   = 1'b1;
                w_use2   = 1'b1;
                w_has_rd = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'b000}: w_dec.alu_op = c_ALU_ADD;
                    {7'h20, 3'b000}: w_dec.alu_op = c_ALU_SUB;
                    {7'h00, 3'b001}: w_dec.alu_op = c_ALU_SLL;
                    {7'h00, 3'b010}: w_dec.alu_op = c_ALU_SLT;
                    {7'h00, 3'b011}: w_dec.alu_op = c_ALU_SLTU;
                    {7'h00, 3'b100}: w_dec.alu_op = c_ALU_XOR;
                    {7'h00, 3'b101}: w_dec.alu_op = c_ALU_SRL;
                    {7'h20, 3'b101}: w_dec.alu_op = c_ALU_SRA;
                    {7'h00, 3'b110}: w_dec.alu_op = c_ALU_OR;
                    {7'h00, 3'b111}: w_dec.alu_op = c_ALU_AND;
                    default:         w_known      = 1'b0;
                endcase
            end
            c_OP_IMM: begin
                w_use1        = 1'b1;
                w_has_rd      = 1'b1;
                w_dec.alu_src = 1'b1;
                w_ext         = 6'b010000;
                case (w_funct3)
                    3'b000: w_dec.alu_op = c_ALU_ADD;
                    3'b010: w_dec.alu_op = c_ALU_SLT;
                    3'b011: w_dec.alu_op = c_ALU_SLTU;
                    3'b100: w_dec.alu_op = c_ALU_XOR;
                    3'b110: w_dec.alu_op = c_ALU_OR;
                    3'b111: w_dec.alu_op = c_ALU_AND;
                    3'b001: begin
                        w_ext        = 6'b100000;
                        w_dec.alu_op = c_ALU_SLL;
                        w_known      = (w_funct7 == 7'h00);
                    end
                    default: begin
                        w_ext        = 6'b100000;
                        w_dec.alu_op = w_funct7[5] ? c_ALU_SRA : c_ALU_SRL;
                        w_known      = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                    end
                endcase
            end
            c_OP_LOAD: begin
                w_use1        = 1'b1;
                w_has_rd      = 1'b1;
                w_dec.alu_op  = c_ALU_ADD;
                w_dec.alu_src = 1'b1;
                w_dec.load    = 1'b1;
                w_dec.wd_sel  = 2'b01;
                w_ext         = 6'b010000;
                case (w_funct3)
                    3'b000:  w_dec.dm_type = c_DM_B;
                    3'b001:  w_dec.dm_type = c_DM_H;
                    3'b010:  w_dec.dm_type = c_DM_W;
                    3'b100:  w_dec.dm_type = c_DM_BU;
                    3'b101:  w_dec.dm_type = c_DM_HU;
                    default: w_known       = 1'b0;
                endcase
            end
            c_OP_STORE: begin
                w_use1          = 1'b1;
                w_use2          = 1'b1;
                w_dec.alu_op    = c_ALU_ADD;
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_ext           = 6'b001000;
                case (w_funct3)
                    3'b000:  w_dec.dm_type = c_DM_B;
                    3'b001:  w_dec.dm_type = c_DM_H;
                    3'b010:  w_dec.dm_type = c_DM_W;
                    default: w_known       = 1'b0;
                endcase
            end
            c_OP_BR: begin
                w_use1       = 1'b1;
                w_use2       = 1'b1;
                w_dec.branch = 1'b1;
                w_dec.funct3 = w_funct3;
                w_ext        = 6'b000100;
                case (w_funct3)
                    3'b000, 3'b001: w_dec.alu_op = c_ALU_SUB;
                    3'b100, 3'b101: w_dec.alu_op = c_ALU_SLT;
                    3'b110, 3'b111: w_dec.alu_op = c_ALU_SLTU;
                    default:        w_known      = 1'b0;
                endcase
            end
            c_OP_JAL: begin
                w_has_rd     = 1'b1;
                w_dec.jal    = 1'b1;
                w_dec.wd_sel = 2'b10;
                w_ext        = 6'b000001;
            end
            c_OP_JALR: begin
                w_use1        = 1'b1;
                w_has_rd      = 1'b1;
                w_dec.jalr    = 1'b1;
                w_dec.alu_op  = c_ALU_ADD;
                w_dec.alu_src = 1'b1;
                w_dec.wd_sel  = 2'b10;
                w_ext         = 6'b010000;
                w_known       = (w_funct3 == 3'b000);
            end
            c_OP_LUI: begin
                w_has_rd      = 1'b1;
                w_dec.alu_op  = c_ALU_LUI;
                w_dec.alu_src = 1'b1;
                w_ext         = 6'b000010;
            end
            c_OP_AUIPC: begin
                w_has_rd      = 1'b1;
                w_dec.alu_op  = c_ALU_AUIPC;
                w_dec.alu_src = 1'b1;
                w_ext         = 6'b000010;
            end
            default: w_known = 1'b0;
        endcase
        // Unread source fields are zeroed so they can never match a writer
        w_dec.rs1       = w_use1   ? id_instr[19:15] : 5'd0;
        w_dec.rs2       = w_use2   ? id_instr[24:20] : 5'd0;
        w_dec.rd        = w_has_rd ? id_instr[11:7]  : 5'd0;
        w_dec.reg_write = w_has_rd && (id_instr[11:7] != 5'd0);
        if (!(w_known && id_valid)) begin
            w_dec = '0;
            w_ext = 6'b000000;
        end
    end

    assign id_EXTOp = rst ? 6'b000000 : w_ext;

    // Branch outcome from the ALU compare result of the EX instruction
    always_comb begin
        w_taken = 1'b0;
        if (r_idex.branch) begin
            case (r_idex.funct3)
                3'b000, 3'b101, 3'b111: w_taken = ex_zero;
                3'b001, 3'b100, 3'b110: w_taken = ~ex_zero;
                default:                w_taken = 1'b0;
            endcase
        end
    end

    assign ex_NPCOp = r_idex.jal  ? 3'b010 :
                      r_idex.jalr ? 3'b100 :
                      w_taken     ? 3'b001 : 3'b000;
    assign flush_o  = (ex_NPCOp != 3'b000);

`ifdef FORWARD_EN
    // Only a load in EX cannot be covered by forwarding
    assign w_hazard = f_hit(r_idex.load, r_idex.rd, w_dec.rs1, w_dec.rs2);

    // Operand selects for the EX instruction; the younger EX/MEM result wins
    always_comb begin
        ex_fwdA = 2'b00;
        ex_fwdB = 2'b00;
        if (f_hit(r_exmem.reg_write, r_exmem.rd, r_idex.rs1, r_idex.rs1))
            ex_fwdA = 2'b10;
        else if (f_hit(r_memwb.reg_write, r_memwb.rd, r_idex.rs1, r_idex.rs1))
            ex_fwdA = 2'b01;
        if (f_hit(r_exmem.reg_write, r_exmem.rd, r_idex.rs2, r_idex.rs2))
            ex_fwdB = 2'b10;
        else if (f_hit(r_memwb.reg_write, r_memwb.rd, r_idex.rs2, r_idex.rs2))
            ex_fwdB = 2'b01;
    end
`else
    // Without forwarding the RF is the only source: wait for every writer to retire
    assign w_hazard = f_hit(r_idex.reg_write,  r_idex.rd,  w_dec.rs1, w_dec.rs2) |
                      f_hit(r_exmem.reg_write, r_exmem.rd, w_dec.rs1, w_dec.rs2) |
                      f_hit(r_memwb.reg_write, r_memwb.rd, w_dec.rs1, w_dec.rs2);
    assign ex_fwdA  = 2'b00;
    assign ex_fwdB  = 2'b00;

    logic w_unused_idex;
    assign w_unused_idex = ^{r_idex.rs1, r_idex.rs2, r_idex.load};
`endif

    // A redirect outranks the hazard: the stalled instruction is squashed anyway
    assign stall_o = w_hazard & ~flush_o;

    // Stage registers; flush or stall loads a bubble into ID/EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            r_idex  <= (flush_o || w_hazard) ? idex_t'('0) : w_dec;
            r_exmem <= '{mem_write: r_idex.mem_write, dm_type: r_idex.dm_type,
                         reg_write: r_idex.reg_write, wd_sel: r_idex.wd_sel,
                         rd: r_idex.rd};
            r_memwb <= '{reg_write: r_exmem.reg_write, wd_sel: r_exmem.wd_sel,
                         rd: r_exmem.rd};
        end
    end

    assign ex_ALUOp     = r_idex.alu_op;
    assign ex_ALUSrc    = r_idex.alu_src;
    assign mem_MemWrite = r_exmem.mem_write;
    assign mem_DMType   = r_exmem.dm_type;
    assign wb_RegWrite  = r_memwb.reg_write;
    assign wb_WDSel     = r_memwb.wd_sel;
    assign wb_rd        = r_memwb.rd;

endmodule
`default_nettype wire
